// File: rtl/ptp_dreq_sched_if.sv
// rtl/ptp_dreq_sched_if.sv - Wishbone write-only bus between scheduler and generator
`timescale 1ns/1ps
interface ptp_dreq_sched_if;
  logic [31:0] addr;
  logic [31:0] data;
  logic        we;
  logic        stb;
  logic        ack;

  modport master (output addr, output data, output we, output stb, input ack);
  modport slave  (input addr, input data, input we, input stb, output ack);
endinterface

// File: rtl/ptp_dreq_sched.sv
// rtl/ptp_dreq_sched.sv - PTP Delay_Req scheduler: tick/trigger, register programming, frame wait
`timescale 1ns/1ps
module ptp_dreq_sched #(
  parameter logic [31:0] BASE_ADDR   = 32'h0300_0100,
  parameter logic [3:0]  MSG_TYPE    = 4'h1,
  parameter int          ACK_TIMEOUT = 16,
  parameter int          TX_TIMEOUT  = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    trig_i,
  input  logic [31:0]             interval_i,
  input  logic [47:0]             tod_sec_i,
  input  logic [31:0]             tod_ns_i,
  ptp_dreq_sched_if.master        wbm,
  input  logic                    mon_tvalid_i,
  input  logic                    mon_tready_i,
  input  logic                    mon_tlast_i,
  output logic                    busy_o,
  output logic [15:0]             seq_id_o,
  output logic                    sent_o,
  output logic                    err_o
);

  localparam int TMAX = (ACK_TIMEOUT > TX_TIMEOUT) ? ACK_TIMEOUT : TX_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    IDLE, W_TSSH, W_TSSL, W_TSNS, W_INFO, W_CTRL, TX_WAIT, DONE
  } state_t;

  state_t        state_q;
  logic [31:0]   ivl_cnt_q, ivl_cnt_d;
  logic          pending_q, pending_d;
  logic [47:0]   sec_q;
  logic [31:0]   ns_q;
  logic [15:0]   seq_q;
  logic [31:0]   addr_q, data_q;
  logic          stb_q, sent_q, err_q;
  logic [TW-1:0] to_cnt_q;

  logic          tick;
  logic [15:0]   seq_next;
  logic [31:0]   wr_off, wr_data;
  state_t        wr_next;
  logic          tx_done;

  // Period counter holds at 0 while disabled so enabling fires a tick at once.
  always_comb begin
    tick      = 1'b0;
    ivl_cnt_d = '0;
    if (en_i && (interval_i != '0)) begin
      if (ivl_cnt_q == '0) begin
        ivl_cnt_d = interval_i - 32'd1;
        tick      = 1'b1;
      end else begin
        ivl_cnt_d = ivl_cnt_q - 32'd1;
      end
    end
  end

  always_comb begin
    pending_d = pending_q | tick | trig_i;
    if ((state_q == IDLE) && pending_q) begin
      pending_d = 1'b0;
    end
  end

  assign seq_next = seq_q + 16'd1;
  assign tx_done  = mon_tvalid_i & mon_tready_i & mon_tlast_i;

  always_comb begin
    wr_off  = 32'h0;
    wr_data = 32'h0;
    wr_next = IDLE;
    case (state_q)
      W_TSSH: begin wr_off = 32'h08; wr_data = {16'h0, sec_q[47:32]};           wr_next = W_TSSL;  end
      W_TSSL: begin wr_off = 32'h0C; wr_data = sec_q[31:0];                     wr_next = W_TSNS;  end
      W_TSNS: begin wr_off = 32'h10; wr_data = ns_q;                            wr_next = W_INFO;  end
      W_INFO: begin wr_off = 32'h04; wr_data = {MSG_TYPE, 12'h0, seq_next};     wr_next = W_CTRL;  end
      W_CTRL: begin wr_off = 32'h00; wr_data = 32'h1;                           wr_next = TX_WAIT; end
      default: begin wr_off = 32'h0; wr_data = 32'h0;                           wr_next = IDLE;    end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ivl_cnt_q <= '0;
      pending_q <= 1'b0;
      sec_q     <= '0;
      ns_q      <= '0;
      seq_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      stb_q     <= 1'b0;
      sent_q    <= 1'b0;
      err_q     <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      ivl_cnt_q <= ivl_cnt_d;
      pending_q <= pending_d;
      sent_q    <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pending_q) begin
            sec_q    <= tod_sec_i;
            ns_q     <= tod_ns_i;
            to_cnt_q <= '0;
            state_q  <= W_TSSH;
          end
        end
        TX_WAIT: begin
          if (tx_done) begin
            sent_q  <= 1'b1;
            seq_q   <= seq_next;
            state_q <= DONE;
          end else if (to_cnt_q == TW'(TX_TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          // Strobe rises one cycle after entering a write state, giving the idle gap.
          if (!stb_q) begin
            stb_q    <= 1'b1;
            addr_q   <= BASE_ADDR + wr_off;
            data_q   <= wr_data;
            to_cnt_q <= '0;
          end else if (wbm.ack) begin
            stb_q    <= 1'b0;
            to_cnt_q <= '0;
            state_q  <= wr_next;
          end else if (to_cnt_q == TW'(ACK_TIMEOUT - 1)) begin
            stb_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign wbm.addr = addr_q;
  assign wbm.data = data_q;
  assign wbm.we   = stb_q;
  assign wbm.stb  = stb_q;
  assign busy_o   = (state_q != IDLE);
  assign seq_id_o = seq_q;
  assign sent_o   = sent_q;
  assign err_o    = err_q;

endmodule
